zoom_vertical: RTL and testbench

//  Streaming 8-bit pixel vertical scaler; the line-direction counterpart of the horizontal zoom stage.

---
 rtl/zoom_vertical.sv | 128 ++++++++++++
 tb/tb_zoom_vertical.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_vertical.sv
// Streaming 8-bit vertical scaler: doubles lines (zoom_in=1) or drops odd lines (zoom_in=0).
// One line is held in a single-port buffer and replayed after it has been forwarded.
module zoom_vertical #(
  parameter int LINE_WIDTH = 320,
  parameter int ADDR_W     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid_in,
  input  logic       sof_in,
  output logic       pixel_ready_out,
  output logic [7:0] pixel_out,
  output logic       pixel_valid_out,
  input  logic       pixel_ready_in,
  input  logic       zoom_in
);

  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_WIDTH - 1);
  localparam logic [ADDR_W:0]   RD_END   = (ADDR_W + 1)'(LINE_WIDTH);

  typedef enum logic {S_PASS, S_REPLAY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   col, col_nxt, col_eff;
  logic                parity, parity_nxt, parity_eff;
  logic                mode_q, mode_nxt, mode_eff;
  logic [ADDR_W:0]     rd_cnt, rd_cnt_nxt;
  logic                rd_vld_p1, rd_vld_nxt;
  logic [DATA_W-1:0]   rd_pix_p1;
  logic [DATA_W-1:0]   line_buf [2**ADDR_W];
  logic [DATA_W-1:0]   pix_nxt;
  logic                vld_nxt;
  logic                sof_v, drop, can_load, out_fire, accept, wr_en, rd_en, load_rep;

  // sof_in restarts an even, forwarded line before the pixel is classified
  always_comb begin
    sof_v           = pixel_valid_in & sof_in;
    col_eff         = sof_v ? '0 : col;
    parity_eff      = sof_v ? 1'b0 : parity;
    mode_eff        = (col_eff == '0) ? zoom_in : mode_q;
    drop            = ~mode_eff & parity_eff;
    can_load        = ~pixel_valid_out | pixel_ready_in;
    out_fire        = pixel_valid_out & pixel_ready_in;
    pixel_ready_out = rst & (state == S_PASS) & (drop | can_load);
    accept          = pixel_valid_in & pixel_ready_out;
    wr_en           = accept & ~drop;
    load_rep        = (state == S_REPLAY) & rd_vld_p1 & can_load;
    rd_en           = (state == S_REPLAY) & (rd_cnt != RD_END) & (~rd_vld_p1 | load_rep);
  end

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    parity_nxt = parity;
    mode_nxt   = mode_q;
    rd_cnt_nxt = rd_cnt;
    rd_vld_nxt = rd_vld_p1;
    pix_nxt    = pixel_out;
    vld_nxt    = pixel_valid_out & ~pixel_ready_in;
    case (state)
      S_PASS: begin
        if (accept) begin
          mode_nxt = mode_eff;
          if (col_eff == LAST_COL) begin
            col_nxt    = '0;
            parity_nxt = ~parity_eff;
            if (mode_eff) state_nxt = S_REPLAY;
          end else begin
            col_nxt    = col_eff + 1'b1;
            parity_nxt = parity_eff;
          end
        end
        if (wr_en) begin
          pix_nxt = pixel_in;
          vld_nxt = 1'b1;
        end
      end
      S_REPLAY: begin
        // rd_pix_p1 is a one-deep prefetch; a new read is issued only when it is free or draining
        if (rd_en) rd_cnt_nxt = rd_cnt + 1'b1;
        rd_vld_nxt = rd_en | (rd_vld_p1 & ~load_rep);
        if (load_rep) begin
          pix_nxt = rd_pix_p1;
          vld_nxt = 1'b1;
        end
        if ((rd_cnt == RD_END) && !rd_vld_p1 && out_fire) begin
          state_nxt  = S_PASS;
          rd_cnt_nxt = '0;
          rd_vld_nxt = 1'b0;
        end
      end
      default: state_nxt = S_PASS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_PASS;
      col             <= '0;
      parity          <= 1'b0;
      mode_q          <= 1'b0;
      rd_cnt          <= '0;
      rd_vld_p1       <= 1'b0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      state           <= state_nxt;
      col             <= col_nxt;
      parity          <= parity_nxt;
      mode_q          <= mode_nxt;
      rd_cnt          <= rd_cnt_nxt;
      rd_vld_p1       <= rd_vld_nxt;
      pixel_out       <= pix_nxt;
      pixel_valid_out <= vld_nxt;
    end
  end

  // Single-port line buffer: writes only in S_PASS, reads only in S_REPLAY
  always_ff @(posedge clk) begin
    if (wr_en)
      line_buf[col_eff] <= pixel_in;
    else if (rd_en)
      rd_pix_p1 <= line_buf[rd_cnt[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_zoom_vertical.sv
// Directed bench for zoom_vertical with LINE_WIDTH=4; output transfers are collected and
// compared against hand-written expected sequences.
module tb_zoom_vertical;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixel_in;
  logic       pixel_valid_in;
  logic       sof_in;
  logic       pixel_ready_out;
  logic [7:0] pixel_out;
  logic       pixel_valid_out;
  logic       pixel_ready_in;
  logic       zoom_in;

  int tests = 0;
  int fails = 0;
  logic [7:0] outs[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  zoom_vertical #(.LINE_WIDTH(4), .ADDR_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .pixel_in(pixel_in),
    .pixel_valid_in(pixel_valid_in),
    .sof_in(sof_in),
    .pixel_ready_out(pixel_ready_out),
    .pixel_out(pixel_out),
    .pixel_valid_out(pixel_valid_out),
    .pixel_ready_in(pixel_ready_in),
    .zoom_in(zoom_in)
  );

  // Inputs change #1 after posedge, so the negedge sees what the next posedge will use
  always @(negedge clk)
    if (rst && pixel_valid_out && pixel_ready_in) outs.push_back(pixel_out);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] p, input logic s);
    pixel_in       = p;
    sof_in         = s;
    pixel_valid_in = 1'b1;
  endtask

  task automatic step();
    logic got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pixel_ready_out) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("accept", {31'd0, got}, 32'd1);
  endtask

  task automatic send(input logic [7:0] p, input logic s);
    drive(p, s);
    step();
  endtask

  task automatic idle();
    pixel_valid_in = 1'b0;
    sof_in         = 1'b0;
    pixel_in       = 8'd0;
  endtask

  task automatic wait_outs(input int n);
    for (int i = 0; i < 200; i++) begin
      if (outs.size() >= n) break;
      @(negedge clk);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag);
    chk($sformatf("%s count", tag), outs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < outs.size()) chk($sformatf("%s[%0d]", tag, i), {24'd0, outs[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    logic seen;
    rst = 1'b0;
    pixel_ready_in = 1'b1;
    zoom_in = 1'b1;
    drive(8'd99, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset pixel_out", {24'd0, pixel_out}, 32'd0);
    chk("reset valid_out", {31'd0, pixel_valid_out}, 32'd0);
    chk("reset ready_out", {31'd0, pixel_ready_out}, 32'd0);
    idle();
    rst = 1'b1;
    #1;
    chk("ready after release", {31'd0, pixel_ready_out}, 32'd1);
    @(posedge clk);
    #1;

    // Test 1: line doubling, input blocked for the whole replay
    outs.delete();
    zoom_in = 1'b1;
    send(8'd10, 1'b1);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    send(8'd40, 1'b0);
    idle();
    chk("t1 ready blocked", {31'd0, pixel_ready_out}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pixel_ready_out) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t1 ready returns", {31'd0, seen}, 32'd1);
    chk("t1 outputs when ready returns", outs.size(), 32'd8);
    @(posedge clk);
    #1;
    wait_outs(8);
    exp_q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd10, 8'd20, 8'd30, 8'd40};
    check_seq("t1");

    // Test 2: decimation drops the odd line
    outs.delete();
    zoom_in = 1'b0;
    send(8'd1, 1'b1);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    for (int p = 5; p <= 8; p++) begin
      drive(8'(p), 1'b0);
      chk($sformatf("t2 ready on %0d", p), {31'd0, pixel_ready_out}, 32'd1);
      if (p > 5) chk($sformatf("t2 valid on %0d", p), {31'd0, pixel_valid_out}, 32'd0);
      step();
    end
    chk("t2 valid after drop", {31'd0, pixel_valid_out}, 32'd0);
    send(8'd9, 1'b0);
    send(8'd10, 1'b0);
    send(8'd11, 1'b0);
    send(8'd12, 1'b0);
    idle();
    wait_outs(8);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10, 8'd11, 8'd12};
    check_seq("t2");

    // Test 3: backpressure on replayed 20
    outs.delete();
    zoom_in = 1'b1;
    send(8'd10, 1'b1);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    send(8'd40, 1'b0);
    idle();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pixel_valid_out && pixel_out == 8'd20) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("t3 replay 20 seen", {31'd0, seen}, 32'd1);
    pixel_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t3 hold data %0d", i), {24'd0, pixel_out}, 32'd20);
      chk($sformatf("t3 hold valid %0d", i), {31'd0, pixel_valid_out}, 32'd1);
    end
    pixel_ready_in = 1'b1;
    wait_outs(8);
    exp_q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd10, 8'd20, 8'd30, 8'd40};
    check_seq("t3");

    // Test 4: mode change mid-line applies from the next line
    outs.delete();
    zoom_in = 1'b1;
    send(8'd1, 1'b1);
    send(8'd2, 1'b0);
    zoom_in = 1'b0;
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    for (int p = 5; p <= 12; p++) send(8'(p), 1'b0);
    idle();
    wait_outs(12);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10, 8'd11, 8'd12};
    check_seq("t4");

    // Test 5: reset during replay
    outs.delete();
    zoom_in = 1'b1;
    send(8'd1, 1'b1);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    idle();
    for (int i = 0; i < 50; i++) begin
      if (outs.size() >= 6) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5 reset valid", {31'd0, pixel_valid_out}, 32'd0);
    chk("t5 reset ready", {31'd0, pixel_ready_out}, 32'd0);
    chk("t5 reset data", {24'd0, pixel_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5 held valid", {31'd0, pixel_valid_out}, 32'd0);
    chk("t5 held ready", {31'd0, pixel_ready_out}, 32'd0);
    rst = 1'b1;
    outs.delete();
    #1;
    chk("t5 ready after release", {31'd0, pixel_ready_out}, 32'd1);
    send(8'd7, 1'b0);
    send(8'd8, 1'b0);
    send(8'd9, 1'b0);
    send(8'd10, 1'b0);
    idle();
    wait_outs(8);
    exp_q = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd7, 8'd8, 8'd9, 8'd10};
    check_seq("t5");

    // Test 6: sof inside a dropped line starts a forwarded line
    outs.delete();
    zoom_in = 1'b0;
    send(8'd60, 1'b1);
    send(8'd61, 1'b0);
    send(8'd62, 1'b0);
    send(8'd63, 1'b0);
    send(8'd70, 1'b0);
    send(8'd71, 1'b0);
    send(8'd50, 1'b1);
    send(8'd51, 1'b0);
    send(8'd52, 1'b0);
    send(8'd53, 1'b0);
    idle();
    wait_outs(8);
    exp_q = '{8'd60, 8'd61, 8'd62, 8'd63, 8'd50, 8'd51, 8'd52, 8'd53};
    check_seq("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
